// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded fetch/execute control sequencer for the 8-bit processor
//
// Purpose:
//   Steps through T-states T0..T4 and decodes (step, opcode, flags) into every
//   datapath load/enable strobe. Each instruction ends on its last active step
//   (instr_done) and the next edge returns to T0. HLT parks the sequencer in a
//   halted state that only clr can leave.
//
// Ports:
//   clk         system clock, all state on rising edge
//   clr         asynchronous active-high reset; forces all outputs to 0 while high
//   run         1 = advance; 0 = freeze step and force all strobes to 0
//   opcode      IR[7:4], valid from T2 onward
//   carry_flag  registered ALU carry flag (used by JC during T2)
//   zero_flag   registered ALU zero flag (used by JZ during T2)
//   step        current T-state
//   hlt         halted, or executing the T2 step of HLT
//   mi..j       MAR-in, RAM-in, RAM-out, IR-out, IR-in, A-in, A-out, B-in,
//               OUT-in, PC-count, PC-out, PC-jump
//   eo, su, fi  ALU enable, ALU subtract, ALU flag load
//   instr_done  high during the last step of each instruction

module control_sequencer #(
    parameter int OP_W   = 4,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic [OP_W-1:0]   opcode,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [STEP_W-1:0] step,
    output logic              hlt,
    output logic              mi,
    output logic              ri,
    output logic              ro,
    output logic              io,
    output logic              ii,
    output logic              ai,
    output logic              ao,
    output logic              bi,
    output logic              oi,
    output logic              ce,
    output logic              co,
    output logic              j,
    output logic              eo,
    output logic              su,
    output logic              fi,
    output logic              instr_done
);

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0011);
    localparam logic [OP_W-1:0] OP_STA = OP_W'(4'b0100);
    localparam logic [OP_W-1:0] OP_LDI = OP_W'(4'b0101);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

    localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

    logic halted;

    // Raw (ungated) microcode decode
    logic d_mi, d_ri, d_ro, d_io, d_ii, d_ai, d_ao, d_bi, d_oi;
    logic d_ce, d_co, d_j, d_eo, d_su, d_fi;
    logic d_done;   // last active step of the current instruction
    logic d_hlt;    // T2 of HLT
    logic d_wrap;   // out-of-range step: return to T0 without strobes
    logic active;   // strobes allowed this cycle

    always_comb begin
        d_mi   = 1'b0;
        d_ri   = 1'b0;
        d_ro   = 1'b0;
        d_io   = 1'b0;
        d_ii   = 1'b0;
        d_ai   = 1'b0;
        d_ao   = 1'b0;
        d_bi   = 1'b0;
        d_oi   = 1'b0;
        d_ce   = 1'b0;
        d_co   = 1'b0;
        d_j    = 1'b0;
        d_eo   = 1'b0;
        d_su   = 1'b0;
        d_fi   = 1'b0;
        d_done = 1'b0;
        d_hlt  = 1'b0;
        d_wrap = 1'b0;

        case (step)
            T0: begin
                d_co = 1'b1;
                d_mi = 1'b1;
            end
            T1: begin
                d_ro = 1'b1;
                d_ii = 1'b1;
                d_ce = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        d_io = 1'b1;
                        d_mi = 1'b1;
                    end
                    OP_LDI: begin
                        d_io   = 1'b1;
                        d_ai   = 1'b1;
                        d_done = 1'b1;
                    end
                    OP_JMP: begin
                        d_io   = 1'b1;
                        d_j    = 1'b1;
                        d_done = 1'b1;
                    end
                    // Conditional jumps look at the live flag inputs; a
                    // not-taken branch is simply an empty step.
                    OP_JC: begin
                        d_io   = carry_flag;
                        d_j    = carry_flag;
                        d_done = 1'b1;
                    end
                    OP_JZ: begin
                        d_io   = zero_flag;
                        d_j    = zero_flag;
                        d_done = 1'b1;
                    end
                    OP_OUT: begin
                        d_ao   = 1'b1;
                        d_oi   = 1'b1;
                        d_done = 1'b1;
                    end
                    OP_HLT: begin
                        d_hlt  = 1'b1;
                        d_done = 1'b1;
                    end
                    default: begin
                        // NOP and undefined opcodes: empty T2, then fetch
                        d_done = 1'b1;
                    end
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        d_ro   = 1'b1;
                        d_ai   = 1'b1;
                        d_done = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        d_ro = 1'b1;
                        d_bi = 1'b1;
                    end
                    OP_STA: begin
                        d_ao   = 1'b1;
                        d_ri   = 1'b1;
                        d_done = 1'b1;
                    end
                    default: begin
                        // Unreachable for valid flow; recover to fetch
                        d_wrap = 1'b1;
                    end
                endcase
            end
            T4: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        d_eo   = 1'b1;
                        d_ai   = 1'b1;
                        d_fi   = 1'b1;
                        d_su   = (opcode == OP_SUB);
                        d_done = 1'b1;
                    end
                    default: begin
                        d_wrap = 1'b1;
                    end
                endcase
            end
            default: begin
                d_wrap = 1'b1;
            end
        endcase
    end

    assign active = run & ~clr & ~halted;

    always_comb begin
        mi         = d_mi   & active;
        ri         = d_ri   & active;
        ro         = d_ro   & active;
        io         = d_io   & active;
        ii         = d_ii   & active;
        ai         = d_ai   & active;
        ao         = d_ao   & active;
        bi         = d_bi   & active;
        oi         = d_oi   & active;
        ce         = d_ce   & active;
        co         = d_co   & active;
        j          = d_j    & active;
        eo         = d_eo   & active;
        su         = d_su   & active;
        fi         = d_fi   & active;
        instr_done = d_done & active;
        hlt        = ~clr & (halted | (d_hlt & active));
    end

    // Step/halt state. While halted, step stays parked at T2 and run is ignored.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step   <= T0;
            halted <= 1'b0;
        end else if (!halted && run) begin
            if (d_hlt) begin
                halted <= 1'b1;
            end else if (d_done || d_wrap) begin
                step <= T0;
            end else begin
                step <= step + STEP_W'(1);
            end
        end
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control unit for the 8-bit processor. Steps through fetch/execute T-states and drives every datapath load/enable strobe, including the ALU's en, sub and flag_en inputs. Takes the opcode from the instruction register and the registered carry/zero flags. Ends each instruction early once its last active step is done, and parks in a halt state on HLT.

Parameters:
OP_W, 4, opcode width (upper nibble of IR)
STEP_W, 3, T-state counter width (steps T0..T4 used)

Ports:
clk  in  1  system clock, all state on rising edge
clr  in  1  asynchronous, active-high reset
run  in  1  1 = advance; 0 = freeze step and force all strobes to 0
opcode  in  OP_W  IR[7:4], valid from T2 onward
carry_flag  in  1  registered ALU carry flag
zero_flag  in  1  registered ALU zero flag
step  out  STEP_W  current T-state
hlt  out  1  halted / halting
mi, ri, ro, io, ii, ai, ao, bi, oi, ce, co, j  out  1 each  MAR-in, RAM-in, RAM-out, IR-out, IR-in, A-in, A-out, B-in, OUT-in, PC-count, PC-out, PC-jump
eo, su, fi  out  1 each  ALU en, ALU sub, ALU flag_en
instr_done  out  1  high during the last step of each instruction

Behaviour:
- State: step register (0..4) plus halted bit. clr async: step=0, halted=0. While clr=1 all outputs are 0.
- Strobes are combinational decode of (step, opcode, flags, halted, run), gated to 0 when run=0 or clr=1.
- Fetch, common to all opcodes: T0: co, mi. T1: ro, ii, ce.
- Execute from T2. Strobes listed per step; "end" means instr_done=1 and the next edge goes to T0.
  - 0001 LDA: T2 io,mi; T3 ro,ai end. 4 cycles.
  - 0010 ADD: T2 io,mi; T3 ro,bi; T4 eo,ai,fi end. 5 cycles.
  - 0011 SUB: as ADD; su=1 only in T4. 5 cycles.
  - 0100 STA: T2 io,mi; T3 ao,ri end. 4 cycles.
  - 0101 LDI: T2 io,ai end.
  - 0110 JMP: T2 io,j end.
  - 0111 JC: T2 io,j if carry_flag=1, else no strobes; end either way.
  - 1000 JZ: T2 io,j if zero_flag=1, else no strobes; end either way.
  - 1110 OUT: T2 ao,oi end.
  - 0000 NOP and all undefined opcodes: T2 no strobes, end.
  - 1111 HLT: T2 hlt=1, instr_done=1. The next edge sets halted.
- Halted: hlt=1, step frozen at 2, all other outputs 0, run ignored. Only clr leaves this state.
- run=0 mid-instruction: step holds and strobes are 0. When run returns to 1, the same step re-executes with full strobes. No step is skipped or doubled.
- Flags are sampled combinationally during T2; the sequencer does not latch them.
- Step never exceeds 4. Any out-of-range step (unreachable) decodes to no strobes and returns to T0.
- clr mid-instruction aborts the instruction; first cycle after release is T0.
- su, eo and fi are never high outside T4 of ADD/SUB.

Test Plan:
- Reset then run=1, opcode=0101: steps 0,1,2,0; T0 co=mi=1; T1 ro=ii=ce=1; T2 io=ai=instr_done=1; no other strobes.
- opcode=0011, run=1: steps 0..4 then 0; at T4 eo=su=fi=ai=1 for exactly one cycle; su=0 at every other step.
- opcode=0111 with carry_flag=0: T2 j=0 and io=0, 3 cycles. Repeat with carry_flag=1: T2 io=j=1. Same pair for 1000 with zero_flag.
- opcode=0001, drop run at T3 for 3 cycles: step stays 3 and strobes are 0. Raise run: ro=ai=1 for one cycle, then T0.
- opcode=1111: T2 hlt=1; afterwards hlt stays 1, step=2 and all strobes are 0 for 10 cycles regardless of run. Pulse clr between edges: outputs go to 0 immediately; after release step=0 and co=mi=1.
- opcode=1010 (undefined): 3-cycle instruction with no T2 strobes and instr_done=1 at T2.
